alu_unit: RTL and testbench

Registered integer ALU for the datapath: takes two WORD_SIZE-bit operands and a 4-bit opcode, and produces a result with zero and carry flags. It sits between the register-file read ports and the writeback mux. The result and flags are captured in output registers, giving a fixed one-cycle latency. The module name is alu_unit.

---
 rtl/alu_pkg.sv | 12 +
 rtl/alu_shifter.sv | 22 ++
 rtl/alu_unit.sv | 59 +++++
 tb/tb_alu_unit.sv | 136 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings shared by the ALU datapath and its testbench
package alu_pkg;
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_NOT = 4'b0101;
    localparam logic [3:0] OP_SHL = 4'b1001;
    localparam logic [3:0] OP_SHR = 4'b1010;
    localparam logic [3:0] OP_SRA = 4'b1011;
endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: combinational SHL/SHR/SRA saturating when the shift amount reaches the word width
module alu_shifter
    import alu_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [W-1:0] d,
    input  logic [W-1:0] amt,
    input  logic [3:0]   op,
    output logic [W-1:0] res
);
    logic           w_big;
    logic [W-1:0]   w_shl;
    logic [W-1:0]   w_shr;
    logic [W-1:0]   w_sra;
    // widened compare so any W >= 2 is representable alongside the amount
    assign w_big = {32'b0, amt} >= (W+32)'(W);
    assign w_shl = w_big ? '0 : d << amt;
    assign w_shr = w_big ? '0 : d >> amt;
    assign w_sra = w_big ? {W{d[W-1]}} : W'($signed(d) >>> amt);
    assign res   = op == OP_SHL ? w_shl : op == OP_SHR ? w_shr : w_sra;
endmodule

// File: rtl/alu_unit.sv
// alu_unit: registered integer ALU with zero and carry flags, one-cycle latency
module alu_unit
    import alu_pkg::*;
#(
    parameter int WORD_SIZE = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] d1,
    input  logic [WORD_SIZE-1:0] d2,
    input  logic [3:0]           op,
    output logic [WORD_SIZE-1:0] out,
    output logic                 iszero,
    output logic                 iscarry
);
    localparam int W = WORD_SIZE;
    logic           w_sub;
    logic           w_arith;
    logic           w_shift_op;
    logic [W:0]     w_sum;
    logic [W-1:0]   w_shift;
    logic [W-1:0]   w_res;
    logic [W-1:0]   r_out;
    logic           r_zero;
    logic           r_carry;
    assign w_sub      = op == OP_SUB;
    assign w_arith    = op == OP_ADD || w_sub;
    assign w_shift_op = op == OP_SHL || op == OP_SHR || op == OP_SRA;
    // one adder serves both: subtraction is d1 + ~d2 + 1
    assign w_sum = {1'b0, d1} + {1'b0, w_sub ? ~d2 : d2} + {{W{1'b0}}, w_sub};
    alu_shifter #(.W(W)) u_shifter (
        .d   (d1),
        .amt (d2),
        .op  (op),
        .res (w_shift)
    );
    always_comb begin
        w_res = w_arith       ? w_sum[W-1:0] :
                op == OP_XOR  ? d1 ^ d2 :
                op == OP_OR   ? d1 | d2 :
                op == OP_AND  ? d1 & d2 :
                op == OP_NOT  ? ~d1 :
                w_shift_op    ? w_shift : d1;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out   <= '0;
            r_zero  <= 1'b1;
            r_carry <= 1'b0;
        end else begin
            r_out   <= w_res;
            r_zero  <= w_res == '0;
            r_carry <= w_arith & w_sum[W];
        end
    end
    assign out     = r_out;
    assign iszero  = r_zero;
    assign iscarry = r_carry;
endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: random and directed checks of alu_unit against a behavioural model
module tb_alu_unit;
    import alu_pkg::*;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] d1 = '0;
    logic [63:0] d2 = '0;
    logic [3:0]  op = '0;
    logic [63:0] out;
    logic        iszero;
    logic        iscarry;
    logic [63:0] exp_out = '0;
    logic        exp_zero = 1'b1;
    logic        exp_carry = 1'b0;
    logic        chk_en = 1'b0;
    int          n_assert = 0;
    int          n_fail = 0;
    alu_unit #(.WORD_SIZE(64)) dut (
        .clk     (clk),
        .rst     (rst),
        .d1      (d1),
        .d2      (d2),
        .op      (op),
        .out     (out),
        .iszero  (iszero),
        .iscarry (iscarry)
    );
    always #5 clk = ~clk;
    // returns {carry, result} straight from the opcode definitions
    function automatic logic [64:0] model(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        logic        c;
        c = 1'b0;
        case (o)
            OP_ADD: {c, r} = {1'b0, a} + {1'b0, b};
            OP_SUB: begin r = a - b; c = a >= b; end
            OP_XOR: r = a ^ b;
            OP_OR:  r = a | b;
            OP_AND: r = a & b;
            OP_NOT: r = ~a;
            OP_SHL: r = b >= 64 ? 64'd0 : a << b[5:0];
            OP_SHR: r = b >= 64 ? 64'd0 : a >> b[5:0];
            OP_SRA: begin
                r = a;
                for (int k = 0; k < 64; k++) if (b > k) r = {a[63], r[63:1]};
            end
            default: r = a;
        endcase
        return {c, r};
    endfunction
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_assert++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask
    always @(posedge clk) begin
        logic [64:0] m;
        m = model(op, d1, d2);
        exp_out   <= rst ? 64'd0 : m[63:0];
        exp_zero  <= rst ? 1'b1 : m[63:0] == 64'd0;
        exp_carry <= rst ? 1'b0 : m[64];
    end
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_out", out, exp_out);
            check("model_zero", {63'd0, iszero}, {63'd0, exp_zero});
            check("model_carry", {63'd0, iscarry}, {63'd0, exp_carry});
        end
    end
    task automatic run(input string name, input logic [3:0] o, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] w_out, input logic w_zero, input logic w_carry);
        op = o;
        d1 = a;
        d2 = b;
        @(posedge clk);
        #2;
        check({name, "_out"}, out, w_out);
        check({name, "_zero"}, {63'd0, iszero}, {63'd0, w_zero});
        check({name, "_carry"}, {63'd0, iscarry}, {63'd0, w_carry});
    endtask
    initial begin
        rst = 1'b1;
        op = 4'hF;
        d1 = 64'h1234;
        d2 = 64'h5678;
        @(posedge clk);
        #2;
        chk_en = 1'b1;
        @(posedge clk);
        #2;
        check("reset_out", out, 64'd0);
        check("reset_zero", {63'd0, iszero}, 64'd1);
        check("reset_carry", {63'd0, iscarry}, 64'd0);
        rst = 1'b0;
        run("add_6_7", OP_ADD, 64'd6, 64'd7, 64'd13, 1'b0, 1'b0);
        run("add_6_m7", OP_ADD, 64'd6, -64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        run("add_wrap", OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b1);
        run("sub_6_7", OP_SUB, 64'd6, 64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        run("sub_7_6", OP_SUB, 64'd7, 64'd6, 64'd1, 1'b0, 1'b1);
        run("sub_5_5", OP_SUB, 64'd5, 64'd5, 64'd0, 1'b1, 1'b1);
        run("and", OP_AND, 64'b1011011, 64'b1100111, 64'd67, 1'b0, 1'b0);
        run("or", OP_OR, 64'b100001, 64'b1001, 64'd41, 1'b0, 1'b0);
        run("xor", OP_XOR, 64'd6, 64'd7, 64'd1, 1'b0, 1'b0);
        run("not", OP_NOT, 64'd0, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        run("invalid", 4'b1111, 64'd33, 64'd9, 64'd33, 1'b0, 1'b0);
        run("invalid_zero", 4'b0110, 64'd0, 64'd9, 64'd0, 1'b1, 1'b0);
        run("shl", OP_SHL, 64'd12, 64'd2, 64'd48, 1'b0, 1'b0);
        run("shr", OP_SHR, 64'd12, 64'd2, 64'd3, 1'b0, 1'b0);
        run("sra", OP_SRA, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000, 1'b0, 1'b0);
        run("shl_64", OP_SHL, 64'd1, 64'd64, 64'd0, 1'b1, 1'b0);
        run("shr_63", OP_SHR, 64'h8000_0000_0000_0000, 64'd63, 64'd1, 1'b0, 1'b0);
        run("sra_big", OP_SRA, 64'h8000_0000_0000_0001, 64'hFFFF_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        run("sra_0", OP_SRA, 64'h8000_0000_0000_0001, 64'd0, 64'h8000_0000_0000_0001, 1'b0, 1'b0);
        run("shl_hi", OP_SHL, 64'd1, 64'h1_0000_0001, 64'd0, 1'b1, 1'b0);
        for (int i = 0; i < 400; i++) begin
            op  = 4'($urandom_range(0, 15));
            d1  = $urandom_range(0, 3) == 0 ? 64'($urandom_range(0, 9)) : {$urandom, $urandom};
            d2  = $urandom_range(0, 2) == 0 ? {$urandom, $urandom} : 64'($urandom_range(0, 70));
            if ($urandom_range(0, 7) == 0) d2 = d1;
            rst = $urandom_range(0, 39) == 0;
            @(posedge clk);
            #2;
        end
        run("pre_rst", OP_ADD, 64'd40, 64'd2, 64'd42, 1'b0, 1'b0);
        rst = 1'b1;
        run("mid_rst", OP_SUB, 64'd9, 64'd1, 64'd0, 1'b1, 1'b0);
        rst = 1'b0;
        run("post_rst", OP_SUB, 64'd9, 64'd1, 64'd8, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
